// File: rtl/br_commit_queue_pkg.sv
// Shared sizing and helpers for the branch commit queue and its predictor update port.
package br_commit_queue_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int BR_Q_DEPTH = 8;

   // A correctly predicted branch keeps the active-low miss flag high.
   function automatic logic pred_hit(input logic pred, input logic taken);
      return pred == taken;
   endfunction

endpackage

// File: rtl/br_commit_queue.sv
// In-order queue of in-flight branches: allocate at fetch, resolve at execute,
// retire at commit with a one-cycle registered update to the predictor.
module br_commit_queue
   import br_commit_queue_pkg::*;
#(
   parameter  int ADDR  = ADDR_WIDTH,
   parameter  int DEPTH = BR_Q_DEPTH,   // power of 2, at least 2
   localparam int PTR   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset_,
   input  logic            flush_,
   input  logic            fetch_br_,
   input  logic [ADDR-1:0] fetch_pc,
   input  logic            fetch_pred,
   output logic [PTR-1:0]  fetch_tag,
   output logic            full,
   output logic            empty,
   input  logic            exe_br_,
   input  logic [PTR-1:0]  exe_tag,
   input  logic            exe_taken,
   input  logic            commit_br_,
   output logic            commit_err,
   output logic [ADDR-1:0] commit_pc,
   output logic            br_commit_,
   output logic            br_result,
   output logic            br_pred_miss_
);

   logic [PTR-1:0]  head, tail;
   logic [PTR:0]    count;
   logic [DEPTH-1:0] valid_q, resolved_q;
   logic [DEPTH-1:0] pred_q, taken_q;
   logic [ADDR-1:0] pc_q [DEPTH];

   logic enq, res, commit_ok, commit_bad;

   assign full      = (count == (PTR+1)'(DEPTH));
   assign empty     = (count == '0);
   assign fetch_tag = tail;

   assign enq        = !fetch_br_ && !full;
   // The slot being allocated is invalid before this edge, so a same-cycle resolve to it is dropped.
   assign res        = !exe_br_ && valid_q[exe_tag] && !(enq && exe_tag == tail);
   assign commit_ok  = !commit_br_ && valid_q[head] && resolved_q[head];
   assign commit_bad = !commit_br_ && !commit_ok;

   // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         valid_q    <= '0;
         resolved_q <= '0;
      end else if (!flush_) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         valid_q    <= '0;
         resolved_q <= '0;
      end else begin
         if (enq) begin
            tail             <= tail + 1'b1;
            valid_q[tail]    <= 1'b1;
            resolved_q[tail] <= 1'b0;
         end
         if (res)
            resolved_q[exe_tag] <= 1'b1;
         // tail == head only when full or empty, so enqueue and commit never collide on a slot.
         if (commit_ok) begin
            head             <= head + 1'b1;
            valid_q[head]    <= 1'b0;
            resolved_q[head] <= 1'b0;
         end
         count <= count + (PTR+1)'(enq) - (PTR+1)'(commit_ok);
      end
   end

   // NOTE: payload storage has no reset; valid_q gates every read, so stale contents are never used.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_q[tail]   <= fetch_pc;
         pred_q[tail] <= fetch_pred;
      end
      if (res)
         taken_q[exe_tag] <= exe_taken;
   end

   // Update port is independent of flush so the branch that triggered it still trains the predictor.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         br_commit_    <= 1'b1;
         commit_err    <= 1'b0;
         commit_pc     <= '0;
         br_result     <= 1'b0;
         br_pred_miss_ <= 1'b1;
      end else begin
         br_commit_ <= !commit_ok;
         commit_err <= commit_bad;
         if (commit_ok) begin
            commit_pc     <= pc_q[head];
            br_result     <= taken_q[head];
            br_pred_miss_ <= pred_hit(pred_q[head], taken_q[head]);
         end else begin
            commit_pc     <= '0;
            br_result     <= 1'b0;
            br_pred_miss_ <= 1'b1;
         end
      end
   end

endmodule

// File: doc/br_commit_queue.md
Name: br_commit_queue

Overview:
- In-order queue of in-flight conditional branches; the producer side of the branch-predictor update interface (commit_pc, br_commit_, br_result, br_pred_miss_).
- Allocates an entry at fetch with the predicted direction and records the actual outcome at execute.
- At commit, retires the head entry and drives one registered update cycle to the predictor counter table.

Parameters:
- ADDR, `AddrWidth, branch PC width.
- DEPTH, `BrQueueDepth (8), entry count; must be a power of 2, minimum 2.
- PTR, $clog2(DEPTH), localparam, tag/pointer width.

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous, active-low reset.
- flush_  in  1  active-low; discard all entries.
- fetch_br_  in  1  active-low; allocate an entry this cycle.
- fetch_pc  in  ADDR  PC of the branch being allocated.
- fetch_pred  in  1  predicted direction (`BrTaken` = 1).
- fetch_tag  out  PTR  tag for the current allocation (tail pointer; combinational).
- full  out  1  queue full; fetch_br_ is ignored while set.
- empty  out  1  queue empty.
- exe_br_  in  1  active-low; branch resolved this cycle.
- exe_tag  in  PTR  tag of the resolved branch.
- exe_taken  in  1  actual direction.
- commit_br_  in  1  active-low; retire the head entry.
- commit_err  out  1  one-cycle pulse: commit requested while empty or while head is unresolved.
- commit_pc  out  ADDR  PC of the retired branch.
- br_commit_  out  1  active-low; predictor update valid.
- br_result  out  1  actual direction of the retired branch.
- br_pred_miss_  out  1  active-low; retired branch was mispredicted.

Behaviour:
- Reset: head = tail = 0, count = 0, all entry valid/resolved bits cleared. full=0, empty=1, commit_err=0, br_commit_=1, br_pred_miss_=1, br_result=0, commit_pc=0.
- Entry fields: pc, pred, taken, valid, resolved. count is PTR+1 bits; full = (count == DEPTH); empty = (count == 0). Both are derived from registered count, never from same-cycle requests.
- Enqueue: when fetch_br_ is low and full is 0, write the entry at tail with valid=1, resolved=0. tail increments modulo DEPTH, wrapping DEPTH-1 -> 0. When full is 1, the request is dropped silently.
- Resolve:
  - When exe_br_ is low and entry[exe_tag].valid is 1, set taken = exe_taken and resolved = 1.
  - A resolve to an invalid entry is ignored. A re-resolve overwrites the stored result.
  - A resolve to the tag being allocated in the same cycle is ignored.
- Commit:
  - When commit_br_ is low, head is valid and head is resolved: invalidate head and increment head modulo DEPTH.
  - Next cycle: br_commit_=0, commit_pc=head.pc, br_result=head.taken, br_pred_miss_ = (head.pred == head.taken).
  - Latency is 1 cycle, with registered outputs held for exactly one cycle. br_commit_ returns to 1 unless another commit occurs.
  - Commit while empty or with head unresolved: no state change, br_commit_ stays 1, commit_err pulses next cycle.
- Simultaneous enqueue and commit: both take effect and count is unchanged. When full, the enqueue is still dropped even if a commit occurs the same cycle. When empty, the enqueue is accepted and the commit errors.
- Simultaneous resolve of the head and commit: the commit sees the pre-resolve state and errors if head was unresolved.
- Flush (flush_ low):
  - Next cycle: head = tail = 0, count = 0, all valid bits cleared.
  - Flush has priority over enqueue and resolve in the same cycle.
  - A legal commit in the flush cycle still produces its update output next cycle; the predictor must see the mispredicted branch that caused the flush.
- Reset mid-operation: asynchronous, immediately restores all reset values; any pending update output is lost.

Decomposition:
- branch.svh: `BrTaken, `BrNotTaken, typedef struct br_q_entry_t {pc, pred, taken, valid, resolved}.
- cpu_config.svh: `BrQueueDepth.
- Single module with no sub-module; pointer/count logic is inline. Optional later split: br_q_ptr (modulo pointer plus count).

Test Plan:
- Reset then idle: empty=1, full=0, br_commit_=1, br_pred_miss_=1 for 10 cycles.
- Enqueue pc 0x100 pred=1 (tag 0); resolve tag 0 taken=1; commit -> next cycle br_commit_=0, commit_pc=0x100, br_result=1, br_pred_miss_=1; then empty=1.
- Enqueue pc 0x200 pred=1; resolve taken=0; commit -> br_result=0, br_pred_miss_=0 for exactly one cycle.
- Fill 8 entries -> full=1. Ninth enqueue with a same-cycle commit: count stays 7 after the commit, the ninth entry is absent, tags wrap 7 -> 0 on the next enqueue.
- Commit with head unresolved, then commit while empty -> commit_err pulses each time, br_commit_ stays 1, head unchanged.
- 3 entries queued, head resolved; commit and flush_ in the same cycle -> update emitted for the head, then empty=1. A following enqueue returns fetch_tag=0.
